pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
- Supervises one PLL instance from its reference-clock domain.
- Generates the PLL's reset and debounces/qualifies its `locked` output.
- Releases N downstream per-domain resets in a staggered sequence.
- Re-runs the sequence (with PLL re-reset on timeout) whenever lock is lost, and keeps a saturating lock-loss statistic.
- Sits beside every PLL wrapper in the design, replacing ad-hoc `locked`-as-reset wiring.

Parameters:
- N_CH, 2, number of downstream reset channels (1..16)
- PLL_RST_LEN, 64, refclk cycles pll_rst is held high per PLL reset
- LOCK_FILT, 1024, consecutive synchronized-locked cycles required before release
- RST_GAP, 16, refclk cycles between successive channel releases (>=1)
- RELOCK_TO, 1048576, max cycles waiting for lock before re-resetting the PLL
- CNT_W, 8, width of loss_cnt

Ports:
- refclk  in  1  block clock (PLL reference clock)
- rst  in  1  asynchronous, active-low block reset
- pll_locked  in  1  PLL locked flag, asynchronous to refclk
- force_relock  in  1  single-cycle request to re-reset the PLL
- clr_cnt  in  1  synchronous clear of loss_cnt
- pll_rst  out  1  active-high reset to PLL
- ch_rst_n  out  N_CH  active-low per-channel resets, bit k released k-th
- all_ready  out  1  high only in S_RUN
- loss_cnt  out  CNT_W  lock losses seen in S_RUN, saturating
- state  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst=0):
  - state=S_PLLRST, pll_rst=1, ch_rst_n=all 0, all_ready=0, loss_cnt=0.
  - All counters are cleared.
- pll_locked passes through a 2-FF synchronizer; lk_s lags the pin by 2 edges. The FSM uses lk_s only.
- S_PLLRST (0):
  - pll_rst=1 for exactly PLL_RST_LEN cycles, then go to S_WAIT.
  - ch_rst_n are all 0 in this state.
- S_WAIT (1):
  - pll_rst=0; the timer counts cycles.
  - lk_s=1: go to S_FILT.
  - Timer reaches RELOCK_TO-1 with lk_s=0: go to S_PLLRST.
- S_FILT (2):
  - Counts consecutive lk_s=1 cycles.
  - lk_s=0: go to S_WAIT, timer restarts from 0.
  - Count reaches LOCK_FILT: go to S_REL.
- S_REL (3):
  - ch_rst_n[0] rises on the first edge in S_REL.
  - ch_rst_n[k] rises k*RST_GAP cycles after ch_rst_n[0].
  - Released bits stay high.
  - One cycle after the last bit rises: go to S_RUN.
- S_RUN (4):
  - all_ready=1.
  - lk_s=0: all ch_rst_n drop to 0 and all_ready drops to 0 on the same edge (3 edges after the pin falls); loss_cnt += 1 (saturating at 2^CNT_W-1); go to S_WAIT.
- Lock loss (lk_s=0) in S_REL:
  - All ch_rst_n drop to 0; go to S_WAIT.
  - loss_cnt is not incremented.
- force_relock:
  - Valid in any state except S_PLLRST; it is ignored in S_PLLRST.
  - Go to S_PLLRST and drop all ch_rst_n.
  - Priority over a simultaneous lock loss; no loss_cnt increment.
- clr_cnt:
  - clr_cnt with a simultaneous increment yields loss_cnt=1.
  - Otherwise loss_cnt=0 on the next edge.
- Channel resets may drop asynchronously only via rst. Per-domain synchronisation of ch_rst_n is the consumer's job.
- Counters are sized by $clog2 of their maximum; no wrap occurs inside a state.

Decomposition:
- Shared package pll_sup_pkg holds:
  - state encoding constants S_PLLRST..S_RUN (3-bit)
  - default parameter values
- One sub-module: bit_sync2, a 2-FF synchronizer with asynchronous active-low reset to 0, used for pll_locked.

Test Plan:
Bench parameters: N_CH=3, PLL_RST_LEN=5, LOCK_FILT=8, RST_GAP=4, RELOCK_TO=50, CNT_W=2.
- Power-up with rst low 3 cycles, then high, pll_locked high from start -> pll_rst high for 5 cycles; ch_rst_n[0] rises 2+8 cycles later; ch_rst_n = 001, 011, 111 at 4-cycle spacing; all_ready=1 one cycle after 111.
- pll_locked held low -> pll_rst re-pulses (5 cycles) every 50 S_WAIT cycles; ch_rst_n stays 000; loss_cnt stays 0.
- Lock glitch of 3 cycles during S_FILT -> return to S_WAIT; filter count restarts; release occurs 8 stable cycles after the glitch ends.
- Drop pll_locked in S_RUN four times -> ch_rst_n=000 exactly 3 edges after each drop; loss_cnt reads 1, 2, 3, 3 (saturates).
- Assert clr_cnt on the same edge as a S_RUN loss -> loss_cnt=1.
- force_relock pulse in S_RUN coincident with lock loss -> state=S_PLLRST, pll_rst=1 for 5 cycles, loss_cnt unchanged.
- Assert rst mid-S_REL -> ch_rst_n=000, pll_rst=1, state=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor: the 3-bit state
//   encoding exposed on the debug `state` port, the default parameter
//   values, and a small constant helper used to size internal counters.
package pll_sup_pkg;

  // FSM state encoding (kept as plain constants so legacy code can
  // compare the debug port against them).
  localparam logic [2:0] S_PLLRST = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_FILT   = 3'd2;
  localparam logic [2:0] S_REL    = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  // Default parameter values.
  localparam int DEF_N_CH        = 2;
  localparam int DEF_PLL_RST_LEN = 64;
  localparam int DEF_LOCK_FILT   = 1024;
  localparam int DEF_RST_GAP     = 16;
  localparam int DEF_RELOCK_TO   = 1048576;
  localparam int DEF_CNT_W       = 8;

  // Larger of two integers, for elaboration-time counter sizing.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// bit_sync2
//   Two-flop synchronizer for a single asynchronous level signal.
//   Both flops clear to 0 on reset, so the output reads "not asserted"
//   until the input has been sampled for two edges.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronized output (lags d by two edges)
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage shift register; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Runs in the PLL reference-clock domain. Pulses the PLL reset, waits
//   for a qualified (filtered) lock, then releases the downstream
//   per-channel resets one after another. Any lock loss pulls all
//   channel resets low again and re-runs the sequence; a lock that never
//   comes within RELOCK_TO cycles re-resets the PLL. Losses seen while
//   fully running are counted in a saturating statistic.
// Ports:
//   refclk       in  block clock (PLL reference clock)
//   rst          in  asynchronous active-low block reset
//   pll_locked   in  PLL lock flag, asynchronous to refclk
//   force_relock in  single-cycle request to re-reset the PLL
//   clr_cnt      in  synchronous clear of loss_cnt
//   pll_rst      out active-high PLL reset
//   ch_rst_n     out active-low channel resets, bit k released k-th
//   all_ready    out high only while fully running
//   loss_cnt     out saturating count of lock losses while running
//   state        out current FSM state (debug)
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int PLL_RST_LEN = DEF_PLL_RST_LEN,
  parameter int LOCK_FILT   = DEF_LOCK_FILT,
  parameter int RST_GAP     = DEF_RST_GAP,
  parameter int RELOCK_TO   = DEF_RELOCK_TO,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_relock,
  input  logic             clr_cnt,
  output logic             pll_rst,
  output logic [N_CH-1:0]  ch_rst_n,
  output logic             all_ready,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [2:0]       state
);

  // Timer value at which S_REL hands over to S_RUN: one cycle after the
  // last channel (released at (N_CH-1)*RST_GAP) has gone high.
  localparam int REL_END = (N_CH - 1) * RST_GAP + 1;
  localparam int CNT_MAX = max2(max2(PLL_RST_LEN, LOCK_FILT), max2(RELOCK_TO, REL_END));
  localparam int TMR_W   = $clog2(CNT_MAX + 1);

  logic              lk_s;
  logic [2:0]        state_r;
  logic [2:0]        next_state_s;
  logic [TMR_W-1:0]  tmr_r;
  logic              tmr_clr_s;
  logic [N_CH-1:0]   ch_rst_n_r;
  logic [N_CH-1:0]   ch_next_s;
  logic [N_CH-1:0]   rel_hit_s;
  logic              pll_rst_r;
  logic              all_ready_r;
  logic [CNT_W-1:0]  loss_cnt_r;
  logic              loss_inc_s;

  bit_sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // Channel k is due for release when the S_REL timer equals k*RST_GAP.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      rel_hit_s[k] = (tmr_r == TMR_W'(k * RST_GAP));
    end
  end

  // Next-state, next channel-reset and loss-increment decode.
  always_comb begin
    next_state_s = state_r;
    ch_next_s    = {N_CH{1'b0}};
    loss_inc_s   = 1'b0;
    if (force_relock && (state_r != S_PLLRST)) begin
      // Forced relock wins over a simultaneous loss and is not counted.
      next_state_s = S_PLLRST;
    end else begin
      case (state_r)
        S_PLLRST: begin
          if (tmr_r == TMR_W'(PLL_RST_LEN - 1)) begin
            next_state_s = S_WAIT;
          end else begin
            next_state_s = S_PLLRST;
          end
        end
        S_WAIT: begin
          if (lk_s) begin
            next_state_s = S_FILT;
          end else if (tmr_r == TMR_W'(RELOCK_TO - 1)) begin
            next_state_s = S_PLLRST;
          end else begin
            next_state_s = S_WAIT;
          end
        end
        S_FILT: begin
          if (!lk_s) begin
            next_state_s = S_WAIT;
          end else if (tmr_r == TMR_W'(LOCK_FILT - 1)) begin
            next_state_s = S_REL;
          end else begin
            next_state_s = S_FILT;
          end
        end
        S_REL: begin
          if (!lk_s) begin
            next_state_s = S_WAIT;
          end else if (tmr_r == TMR_W'(REL_END)) begin
            next_state_s = S_RUN;
            ch_next_s    = ch_rst_n_r;
          end else begin
            next_state_s = S_REL;
            ch_next_s    = ch_rst_n_r | rel_hit_s;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            next_state_s = S_WAIT;
            loss_inc_s   = 1'b1;
          end else begin
            next_state_s = S_RUN;
            ch_next_s    = ch_rst_n_r;
          end
        end
        default: begin
          next_state_s = S_PLLRST;
        end
      endcase
    end
  end

  // The shared timer restarts from 0 on every state change.
  assign tmr_clr_s = (next_state_s != state_r);

  // State, timer and registered outputs.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_PLLRST;
      tmr_r       <= {TMR_W{1'b0}};
      ch_rst_n_r  <= {N_CH{1'b0}};
      pll_rst_r   <= 1'b1;
      all_ready_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      ch_rst_n_r  <= ch_next_s;
      pll_rst_r   <= (next_state_s == S_PLLRST);
      all_ready_r <= (next_state_s == S_RUN);
      if (tmr_clr_s) begin
        tmr_r <= {TMR_W{1'b0}};
      end else if (state_r != S_RUN) begin
        tmr_r <= tmr_r + TMR_W'(32'd1);
      end else begin
        // S_RUN has no timeout; holding the timer avoids a long-run wrap.
        tmr_r <= tmr_r;
      end
    end
  end

  // Saturating lock-loss statistic; a clear coinciding with a loss
  // leaves exactly that one loss recorded.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      loss_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      loss_cnt_r <= loss_inc_s ? CNT_W'(32'd1) : {CNT_W{1'b0}};
    end else if (loss_inc_s && (loss_cnt_r != {CNT_W{1'b1}})) begin
      loss_cnt_r <= loss_cnt_r + CNT_W'(32'd1);
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign pll_rst   = pll_rst_r;
  assign ch_rst_n  = ch_rst_n_r;
  assign all_ready = all_ready_r;
  assign loss_cnt  = loss_cnt_r;
  assign state     = state_r;

endmodule
